scope_channel: RTL and testbench
================================

// Module: scope_channel
// PURPOSE
//  One oscilloscope acquisition channel, placed between the ADC pins and the tx_protocol arbiter.
//  - Drives the ADC clock and captures raw samples.
//  - Decimates the samples and feeds them to the trigger block.
//  - Stores samples in a circular RAM while we=1.
//  - On request, streams the last num_samples samples out over a simple interface (SI).
//  - Holds the analog front-end and DAC-offset settings written over the shared register bus.
// PARAMETERS
//  BITS_ADC=8              ADC sample width
//  BITS_DAC=10             DAC offset value width
//  REG_ADDR_WIDTH=8        register bus address width
//  REG_DATA_WIDTH=16       register bus data width
//  TX_DATA_WIDTH=8         SI output width; must equal RAM_DATA_WIDTH
//  RAM_DATA_WIDTH=8        buffer word width; must be >= BITS_ADC
//  RAM_SIZE=4096           buffer depth; power of two
//  ADDR_CH_SETTINGS=7      address of the settings register
//  ADDR_DAC_VALUE=9        address of the DAC register
//  ADDR_ADC_CLK_DIV=1      address of the decimation register
//  ADDR_N_MOVING_AVERAGE=5 address of the averaging-order register
//  DEFAULT_CH_SETTINGS=8'h80       reset value of the settings register
//  DEFAULT_DAC_VALUE=512           reset value of the DAC register
//  DEFAULT_ADC_CLK_DIV=0           reset value of the decimation register
//  DEFAULT_N_MOVING_AVERAGE=0      reset value of the averaging-order register
//  MA_ACUM_WIDTH=16        moving-average accumulator width; must be >= BITS_ADC+7
// PORTS
//  clk            in   1        system clock, 100 MHz
//  rst            in   1        asynchronous reset, active low
//  adc_input      in   BITS_ADC ADC data pins
//  adc_oe         out  1        ADC output enable, active high
//  adc_clk_o      out  1        ADC clock
//  Att_Sel        out  3        attenuator mux select
//  Gain_Sel       out  3        gain mux select
//  DC_Coupling    out  1        1 = DC coupling
//  dac_value_o    out  BITS_DAC offset DAC code
//  rqst_data      in   1        one-cycle pulse: send the buffer contents
//  we             in   1        buffer write enable, from the trigger block
//  num_samples    in   REG_DATA_WIDTH  number of samples to send
//  register_addr  in   REG_ADDR_WIDTH  register bus address
//  register_data  in   REG_DATA_WIDTH  register bus data
//  reg_rdy        in   1        register bus strobe
//  adc_data_o     out  BITS_ADC decimated sample
//  adc_rdy_o      out  1        one-cycle valid strobe for adc_data_o
//  tx_data        out  TX_DATA_WIDTH  SI data
//  tx_rdy         out  1        SI data valid
//  tx_eof         out  1        marks the last word of a transfer
//  tx_ack         in   1        SI acknowledge from the consumer
// BEHAVIOUR
//  Reset: every register takes its DEFAULT_* value; all pointers and counters clear.
//   Outputs in reset: tx_rdy=0, tx_eof=0, adc_rdy_o=0, adc_clk_o=0, adc_data_o=0, tx_data=0.
//  Register bus: on a cycle with reg_rdy=1 and register_addr matching an address, that register loads register_data.
//   The new value is visible on the next cycle; non-matching addresses are ignored.
//  Settings register bit map:
//   [2:0] Att_Sel, [5:3] Gain_Sel, [6] DC_Coupling, [7] channel on, which drives adc_oe.
//  dac_value_o = DAC register[BITS_DAC-1:0].
//  ADC clock: adc_clk_o toggles every clk cycle (50 MHz).
//   A raw sample of adc_input is registered on the cycle where adc_clk_o goes 1 -> 0.
//  Decimator: counts raw samples 0..div, where div is the decimation register.
//   On wrap it updates adc_data_o and pulses adc_rdy_o for one cycle.
//   So one output is produced per (div+1) raw samples; div=0 gives one output every 2 clk cycles.
//  Buffer write: on adc_rdy_o && we && state==IDLE, write RAM[wr_ptr] and increment wr_ptr modulo RAM_SIZE.
//  Buffer read FSM, states IDLE -> FETCH -> SEND:
//   - rqst_data in IDLE with n = min(num_samples, RAM_SIZE) > 0:
//     rd_ptr = wr_ptr - n (mod RAM_SIZE), count = n, go to FETCH.
//   - FETCH: synchronous RAM read with 1-cycle latency; then SEND with tx_rdy=1.
//   - SEND: tx_data stays stable until tx_ack; tx_eof=1 while count==1.
//     On tx_ack: tx_rdy drops; the FSM goes to IDLE if this was the last word, otherwise to FETCH with the next address.
//  Boundary cases:
//   - rqst_data while busy, or with num_samples==0: ignored.
//   - Buffer writes are blocked outside IDLE.
//   - Reset mid-transfer aborts it; tx_rdy drops immediately.
// CONFIGURATION
//  CHANNEL_MOVING_AVERAGE_EN defined:
//   - Register ADDR_N_MOVING_AVERAGE holds N; values above 7 are clamped to 7.
//   - Raw samples are summed in an MA_ACUM_WIDTH accumulator.
//   - Every 2^N raw samples, acc>>N is fed to the decimator instead of the raw sample.
//   - N=0 behaves exactly like the raw path.
//  Not defined: the ADDR_N_MOVING_AVERAGE register is not decoded and raw samples feed the decimator directly.
// TESTING
//  Reset: Att_Sel=0, Gain_Sel=0, DC_Coupling=0, adc_oe=1, dac_value_o=512, tx_rdy=0.
//  Write 0x004D to ADDR_CH_SETTINGS: Att_Sel=5, Gain_Sel=1, DC_Coupling=1, adc_oe=0 on the next cycle.
//   Writes to other addresses leave all outputs unchanged.
//  div=3 with a ramp on adc_input: adc_rdy_o pulses every 8 clk cycles, and adc_data_o steps by 4 raw codes per pulse.
//  we=1 for 10 samples 0..9, then num_samples=4 and rqst_data:
//   tx sends 6,7,8,9 with tx_ack held high; tx_eof=1 only on 9.
//   tx_data stays stable while tx_ack is held low.
//  Wrap and boundary:
//   - After RAM_SIZE+3 writes, a request for RAM_SIZE returns the oldest surviving samples in order.
//   - num_samples=0 produces no tx_rdy.
//   - A second rqst_data during a transfer is ignored.
//  With CHANNEL_MOVING_AVERAGE_EN, N=2, and raw samples 4,8,12,16: the averaged sample 10 is delivered.

Source files
------------

// File: rtl/scope_channel_if.sv
// scope_channel_if
//   Groups the two bus-style connections of an acquisition channel:
//   the shared register write bus (register_addr, register_data, reg_rdy)
//   and the simple interface (SI) towards the tx arbiter
//   (tx_data, tx_rdy, tx_eof, tx_ack).
//   modport master : channel side (drives SI data, receives ack and register writes)
//   modport slave  : arbiter / register-bus side
interface scope_channel_if #(
    parameter int REG_ADDR_WIDTH = 8,
    parameter int REG_DATA_WIDTH = 16,
    parameter int TX_DATA_WIDTH  = 8
);
    logic [REG_ADDR_WIDTH-1:0] register_addr;
    logic [REG_DATA_WIDTH-1:0] register_data;
    logic                      reg_rdy;
    logic [TX_DATA_WIDTH-1:0]  tx_data;
    logic                      tx_rdy;
    logic                      tx_eof;
    logic                      tx_ack;

    modport master (
        input  register_addr, register_data, reg_rdy, tx_ack,
        output tx_data, tx_rdy, tx_eof
    );

    modport slave (
        output register_addr, register_data, reg_rdy, tx_ack,
        input  tx_data, tx_rdy, tx_eof
    );
endinterface

// File: rtl/scope_channel.sv
// scope_channel
//   One oscilloscope acquisition channel: generates the ADC clock, captures
//   raw samples, decimates them, keeps a circular history buffer and streams
//   the last num_samples words out on request. Also holds the analog
//   front-end settings and the DAC offset written over the register bus.
// Ports
//   clk, rst             system clock, asynchronous active-low reset
//   adc_input            ADC data pins
//   adc_oe, adc_clk_o    ADC output enable, ADC clock (clk/2)
//   Att_Sel, Gain_Sel,
//   DC_Coupling          front-end settings (settings register bits)
//   dac_value_o          offset DAC code
//   rqst_data            pulse: send the last num_samples buffered samples
//   we                   buffer write enable from the trigger block
//   num_samples          transfer length
//   adc_data_o/adc_rdy_o decimated sample and its one-cycle strobe
//   bus                  register bus + SI (scope_channel_if.master)
// Optional feature: define CHANNEL_MOVING_AVERAGE_EN to insert a 2^N
//   block-average stage (N at ADDR_N_MOVING_AVERAGE) ahead of the decimator.
module scope_channel #(
    parameter int BITS_ADC                 = 8,
    parameter int BITS_DAC                 = 10,
    parameter int REG_ADDR_WIDTH           = 8,
    parameter int REG_DATA_WIDTH           = 16,
    parameter int TX_DATA_WIDTH            = 8,
    parameter int RAM_DATA_WIDTH           = 8,
    parameter int RAM_SIZE                 = 4096,
    parameter int ADDR_CH_SETTINGS         = 7,
    parameter int ADDR_DAC_VALUE           = 9,
    parameter int ADDR_ADC_CLK_DIV         = 1,
    parameter int ADDR_N_MOVING_AVERAGE    = 5,
    parameter int DEFAULT_CH_SETTINGS      = 'h80,
    parameter int DEFAULT_DAC_VALUE        = 512,
    parameter int DEFAULT_ADC_CLK_DIV      = 0,
    parameter int DEFAULT_N_MOVING_AVERAGE = 0,
    parameter int MA_ACUM_WIDTH            = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BITS_ADC-1:0]       adc_input,
    output logic                      adc_oe,
    output logic                      adc_clk_o,
    output logic [2:0]                Att_Sel,
    output logic [2:0]                Gain_Sel,
    output logic                      DC_Coupling,
    output logic [BITS_DAC-1:0]       dac_value_o,
    input  logic                      rqst_data,
    input  logic                      we,
    input  logic [REG_DATA_WIDTH-1:0] num_samples,
    output logic [BITS_ADC-1:0]       adc_data_o,
    output logic                      adc_rdy_o,
    scope_channel_if.master           bus
);
    localparam int AW = $clog2(RAM_SIZE);
    localparam int CW = AW + 1;

    // Parameter legality checks
    if (TX_DATA_WIDTH != RAM_DATA_WIDTH || RAM_DATA_WIDTH < BITS_ADC) begin : g_bad_width
        $error("scope_channel: TX_DATA_WIDTH must equal RAM_DATA_WIDTH, RAM_DATA_WIDTH >= BITS_ADC");
    end
    if ((RAM_SIZE & (RAM_SIZE - 1)) != 0 || MA_ACUM_WIDTH < BITS_ADC + 7
        || DEFAULT_N_MOVING_AVERAGE > 7) begin : g_bad_size
        $error("scope_channel: RAM_SIZE / MA_ACUM_WIDTH / DEFAULT_N_MOVING_AVERAGE out of range");
    end
    if (ADDR_N_MOVING_AVERAGE >= (1 << REG_ADDR_WIDTH) || ADDR_CH_SETTINGS >= (1 << REG_ADDR_WIDTH)
        || ADDR_DAC_VALUE >= (1 << REG_ADDR_WIDTH) || ADDR_ADC_CLK_DIV >= (1 << REG_ADDR_WIDTH)) begin : g_bad_addr
        $error("scope_channel: register address does not fit REG_ADDR_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
    state_t state, state_nx;

    // ---------------- register bank ----------------
    logic [7:0]                ch_settings;
    logic [BITS_DAC-1:0]       dac_reg;
    logic [REG_DATA_WIDTH-1:0] clk_div;
`ifdef CHANNEL_MOVING_AVERAGE_EN
    logic [2:0]                ma_n;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_settings <= 8'(DEFAULT_CH_SETTINGS);
            dac_reg     <= BITS_DAC'(DEFAULT_DAC_VALUE);
            clk_div     <= REG_DATA_WIDTH'(DEFAULT_ADC_CLK_DIV);
`ifdef CHANNEL_MOVING_AVERAGE_EN
            ma_n        <= 3'(DEFAULT_N_MOVING_AVERAGE);
`endif
        end else if (bus.reg_rdy) begin
            if (bus.register_addr == REG_ADDR_WIDTH'(ADDR_CH_SETTINGS))
                ch_settings <= bus.register_data[7:0];
            if (bus.register_addr == REG_ADDR_WIDTH'(ADDR_DAC_VALUE))
                dac_reg <= bus.register_data[BITS_DAC-1:0];
            if (bus.register_addr == REG_ADDR_WIDTH'(ADDR_ADC_CLK_DIV))
                clk_div <= bus.register_data;
`ifdef CHANNEL_MOVING_AVERAGE_EN
            if (bus.register_addr == REG_ADDR_WIDTH'(ADDR_N_MOVING_AVERAGE))
                ma_n <= (bus.register_data > REG_DATA_WIDTH'(7)) ? 3'd7 : bus.register_data[2:0];
`endif
        end
    end

    always_comb begin
        Att_Sel     = ch_settings[2:0];
        Gain_Sel    = ch_settings[5:3];
        DC_Coupling = ch_settings[6];
        adc_oe      = ch_settings[7];
        dac_value_o = dac_reg;
    end

    // ---------------- ADC capture ----------------
    // Sample is taken on the edge where adc_clk_o falls, i.e. half an ADC
    // period after the ADC was clocked, when its output is settled.
    logic [BITS_ADC-1:0] raw_sample;
    logic                raw_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adc_clk_o  <= 1'b0;
            raw_vld    <= 1'b0;
            raw_sample <= '0;
        end else begin
            adc_clk_o <= ~adc_clk_o;
            raw_vld   <= adc_clk_o;
            if (adc_clk_o)
                raw_sample <= adc_input;
        end
    end

    // ---------------- optional block average ----------------
    logic                dec_vld;
    logic [BITS_ADC-1:0] dec_sample;

`ifdef CHANNEL_MOVING_AVERAGE_EN
    logic [MA_ACUM_WIDTH-1:0] ma_acc, ma_sum;
    logic [6:0]               ma_cnt, ma_last;

    // The closing sample of a block is added combinationally so that N=0
    // has exactly the timing of the raw path.
    always_comb begin
        ma_sum     = ma_acc + MA_ACUM_WIDTH'(raw_sample);
        ma_last    = ~(7'h7f << ma_n);
        dec_vld    = raw_vld && (ma_cnt >= ma_last);
        dec_sample = BITS_ADC'(ma_sum >> ma_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma_acc <= '0;
            ma_cnt <= '0;
        end else if (raw_vld) begin
            if (ma_cnt >= ma_last) begin
                ma_acc <= '0;
                ma_cnt <= '0;
            end else begin
                ma_acc <= ma_sum;
                ma_cnt <= ma_cnt + 7'd1;
            end
        end
    end
`else
    always_comb begin
        dec_vld    = raw_vld;
        dec_sample = raw_sample;
    end
`endif

    // ---------------- decimator ----------------
    // >= rather than == so a smaller div written mid-count wraps at once.
    logic [REG_DATA_WIDTH-1:0] dec_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_cnt    <= '0;
            adc_data_o <= '0;
            adc_rdy_o  <= 1'b0;
        end else begin
            adc_rdy_o <= 1'b0;
            if (dec_vld) begin
                if (dec_cnt >= clk_div) begin
                    dec_cnt    <= '0;
                    adc_data_o <= dec_sample;
                    adc_rdy_o  <= 1'b1;
                end else begin
                    dec_cnt <= dec_cnt + REG_DATA_WIDTH'(1);
                end
            end
        end
    end

    // ---------------- circular buffer ----------------
    logic [RAM_DATA_WIDTH-1:0] ram [RAM_SIZE];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             count, n_req;
    logic                      buf_we, start;

    always_comb begin
        buf_we = adc_rdy_o && we && (state == IDLE);
        n_req  = (32'(num_samples) > 32'(RAM_SIZE)) ? CW'(RAM_SIZE) : CW'(num_samples);
        start  = rqst_data && (state == IDLE) && (n_req != '0);
    end

    always_ff @(posedge clk) begin
        if (buf_we)
            ram[wr_ptr] <= RAM_DATA_WIDTH'(adc_data_o);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wr_ptr <= '0;
        else if (buf_we)
            wr_ptr <= wr_ptr + AW'(1);
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        bus.tx_rdy  = 1'b0;
        bus.tx_eof  = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = FETCH;
            FETCH: state_nx = SEND;
            SEND: begin
                bus.tx_rdy = 1'b1;
                bus.tx_eof = (count == CW'(1));
                if (bus.tx_ack)
                    state_nx = (count == CW'(1)) ? IDLE : FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Truncating n_req to AW bits maps a full-buffer request onto rd_ptr=wr_ptr,
    // which is the oldest surviving sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            count       <= '0;
            bus.tx_data <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rd_ptr <= wr_ptr - AW'(n_req);
                    count  <= n_req;
                end
                FETCH: bus.tx_data <= TX_DATA_WIDTH'(ram[rd_ptr]);
                SEND: if (bus.tx_ack) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    count  <= count - CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_scope_channel.sv
// tb_scope_channel
//   Self-checking bench for scope_channel. A small ADC model presents a new
//   value on every rising adc_clk_o; the bench predicts decimator output and
//   buffer contents from the sequence of presented values.
module tb_scope_channel;
    localparam int RAM_SIZE = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  adc_input;
    logic        adc_oe, adc_clk_o, DC_Coupling, adc_rdy_o;
    logic [2:0]  Att_Sel, Gain_Sel;
    logic [9:0]  dac_value_o;
    logic        rqst_data = 1'b0;
    logic        we = 1'b0;
    logic [15:0] num_samples = '0;
    logic [7:0]  adc_data_o;

    scope_channel_if #(.REG_ADDR_WIDTH(8), .REG_DATA_WIDTH(16), .TX_DATA_WIDTH(8)) bus ();

    scope_channel #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk(clk), .rst(rst), .adc_input(adc_input), .adc_oe(adc_oe), .adc_clk_o(adc_clk_o),
        .Att_Sel(Att_Sel), .Gain_Sel(Gain_Sel), .DC_Coupling(DC_Coupling),
        .dac_value_o(dac_value_o), .rqst_data(rqst_data), .we(we), .num_samples(num_samples),
        .adc_data_o(adc_data_o), .adc_rdy_o(adc_rdy_o), .bus(bus.master)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- ADC model ----------------
    int unsigned adc_mode = 0;   // 0 ramp, 1 random, 2 pattern 4,8,12,16
    int unsigned ramp_val = 0;
    logic [7:0]  presented[$];

    initial begin
        adc_input = '0;
        forever begin
            @(posedge adc_clk_o);
            #1;
            if (rst) begin
                case (adc_mode)
                    0: adc_input = 8'(ramp_val);
                    1: adc_input = 8'($urandom_range(0, 255));
                    default: adc_input = 8'(4 * ((ramp_val % 4) + 1));
                endcase
                ramp_val++;
                presented.push_back(adc_input);
            end
        end
    end

    // ---------------- reference model of stream + buffer ----------------
    int unsigned pulse_idx = 0;
    bit          chk_stream = 1'b0;
    bit          xfer_active = 1'b0;
    logic [7:0]  mem_q[$];
    int unsigned cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst && adc_rdy_o) begin
            if (chk_stream)
                check_val("adc_stream", adc_data_o,
                          (pulse_idx < presented.size()) ? presented[pulse_idx] : 8'bx);
            if (we && !xfer_active && pulse_idx < presented.size())
                mem_q.push_back(presented[pulse_idx]);
            pulse_idx++;
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        rst = 1'b0; we = 1'b0; rqst_data = 1'b0; bus.tx_ack = 1'b0; bus.reg_rdy = 1'b0;
        repeat (2) @(negedge clk);
        presented.delete(); mem_q.delete();
        pulse_idx = 0; ramp_val = 0; xfer_active = 1'b0;
        rst = 1'b1;
    endtask

    task automatic reg_write(input int unsigned addr, input int unsigned data);
        @(posedge clk); #1;
        bus.register_addr = 8'(addr); bus.register_data = 16'(data); bus.reg_rdy = 1'b1;
        @(posedge clk); #1;
        bus.reg_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx_rdy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.tx_rdy) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (adc_rdy_o) begin ok = 1'b1; return; end
        end
    endtask

    task automatic fill_buffer(input int unsigned n_new);
        int unsigned target;
        bit ok;
        target = mem_q.size() + n_new;
        @(posedge clk); #1; we = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4 * int'(n_new) + 100; i++) begin
            @(negedge clk);
            if (mem_q.size() >= target) begin ok = 1'b1; break; end
        end
        check_val("fill_wait", ok, 1);
        @(posedge clk); #1; we = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic do_xfer(input int unsigned n, input bit hold_ack, input bit dup_rqst, input bit we_during);
        logic [7:0]  exp_q[$];
        logic [7:0]  held;
        int unsigned m, d, extra;
        bit ok;
        m = (n > RAM_SIZE) ? RAM_SIZE : n;
        for (int unsigned i = 0; i < m; i++) exp_q.push_back(mem_q[mem_q.size() - m + i]);
        @(posedge clk); #1;
        num_samples = 16'(n); rqst_data = 1'b1; xfer_active = 1'b1; bus.tx_ack = hold_ack;
        @(posedge clk); #1;
        rqst_data = 1'b0;
        for (int unsigned i = 0; i < m; i++) begin
            wait_tx_rdy(ok);
            check_val("tx_wait", ok, 1);
            if (!ok) break;
            check_val("tx_data", bus.tx_data, exp_q[i]);
            check_val("tx_eof", bus.tx_eof, (i == m - 1));
            if (hold_ack) begin
                @(posedge clk);
            end else begin
                held = bus.tx_data;
                if (i == 0 && dup_rqst) begin
                    @(posedge clk); #1; num_samples = 16'd3; rqst_data = 1'b1;
                    @(posedge clk); #1; rqst_data = 1'b0;
                end
                if (i == 0 && we_during) begin
                    @(posedge clk); #1; we = 1'b1;
                end
                d = $urandom_range(0, 3) + ((i == 0 && we_during) ? 12 : 0);
                repeat (d) begin
                    @(negedge clk);
                    check_val("tx_hold", {bus.tx_rdy, bus.tx_data}, {1'b1, held});
                end
                @(posedge clk); #1; we = 1'b0; bus.tx_ack = 1'b1;
                @(posedge clk);
            end
            #1; bus.tx_ack = 1'b0;
            if (hold_ack && i != m - 1) bus.tx_ack = 1'b1;
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.tx_rdy) extra++;
        end
        check_val("tx_extra", extra, 0);
        xfer_active = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned t_prev, d_prev, cnt0;
        bit ok;
        bus.tx_ack = 1'b0; bus.reg_rdy = 1'b0; bus.register_addr = '0; bus.register_data = '0;

        // reset values
        repeat (2) @(negedge clk);
        check_val("rst_tx_rdy", bus.tx_rdy, 0);
        check_val("rst_tx_eof", bus.tx_eof, 0);
        check_val("rst_tx_data", bus.tx_data, 0);
        check_val("rst_adc_rdy", adc_rdy_o, 0);
        check_val("rst_adc_clk", adc_clk_o, 0);
        check_val("rst_adc_data", adc_data_o, 0);
        check_val("rst_front", {adc_oe, DC_Coupling, Gain_Sel, Att_Sel}, 8'h80);
        check_val("rst_dac", dac_value_o, 512);
        do_reset();
        chk_stream = 1'b1;

        // register bus
        reg_write(7, 'h004D);
        check_val("set_att", Att_Sel, 5);
        check_val("set_gain", Gain_Sel, 1);
        check_val("set_dc", DC_Coupling, 1);
        check_val("set_oe", adc_oe, 0);
        for (int k = 0; k < 4; k++) begin
            reg_write((k == 0) ? 8 : $urandom_range(10, 255), $urandom_range(0, 65535));
            check_val("other_addr", {adc_oe, DC_Coupling, Gain_Sel, Att_Sel, dac_value_o}, {8'h4D, 10'd512});
        end
        for (int k = 0; k < 2; k++) begin
            d_prev = $urandom_range(0, 65535);
            reg_write(9, d_prev);
            check_val("dac_write", dac_value_o, d_prev & 'h3FF);
        end

        // decimation by 4 on a ramp
        chk_stream = 1'b0;
        reg_write(1, 3);
        repeat (3) wait_pulse(ok);
        wait_pulse(ok);
        check_val("dec_wait", ok, 1);
        t_prev = cyc; d_prev = adc_data_o;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(ok);
            check_val("dec_wait", ok, 1);
            check_val("dec_period", cyc - t_prev, 8);
            check_val("dec_step", 8'(adc_data_o - 8'(d_prev)), 4);
            t_prev = cyc; d_prev = adc_data_o;
        end

        // 10 ramp samples, last 4 requested
        do_reset();
        chk_stream = 1'b1; adc_mode = 0;
        fill_buffer(10);
        check_val("ten_written", mem_q.size(), 10);
        check_val("ten_last", mem_q[9], 9);
        do_xfer(4, 1'b1, 1'b0, 1'b0);
        do_xfer(4, 1'b0, 1'b1, 1'b1);   // duplicate rqst ignored, writes blocked while busy
        do_xfer(4, 1'b0, 1'b0, 1'b0);

        // zero-length request
        @(posedge clk); #1; num_samples = '0; rqst_data = 1'b1;
        @(posedge clk); #1; rqst_data = 1'b0;
        cnt0 = 0;
        repeat (10) begin @(negedge clk); if (bus.tx_rdy) cnt0++; end
        check_val("zero_len", cnt0, 0);

        // reset in the middle of a transfer
        @(posedge clk); #1; num_samples = 16'd3; rqst_data = 1'b1;
        @(posedge clk); #1; rqst_data = 1'b0;
        wait_tx_rdy(ok);
        check_val("abort_wait", ok, 1);
        #2 rst = 1'b0;
        #1;
        check_val("abort_tx_rdy", bus.tx_rdy, 0);
        check_val("abort_tx_data", bus.tx_data, 0);
        do_reset();
        cnt0 = 0;
        repeat (6) begin @(negedge clk); if (bus.tx_rdy) cnt0++; end
        check_val("abort_idle", cnt0, 0);

        // wrap-around with random data
        adc_mode = 1;
        fill_buffer(RAM_SIZE + 3);
        do_xfer(RAM_SIZE, 1'b1, 1'b0, 1'b0);
        do_xfer(5000, 1'b1, 1'b0, 1'b0);

        // randomized write / read rounds
        for (int r = 0; r < 5; r++) begin
            fill_buffer($urandom_range(1, 30));
            do_xfer($urandom_range(1, 24), $urandom_range(0, 1), 1'b0, 1'b0);
        end

`ifdef CHANNEL_MOVING_AVERAGE_EN
        do_reset();
        chk_stream = 1'b0; adc_mode = 2;
        reg_write(5, 2);
        repeat (4) wait_pulse(ok);
        t_prev = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_pulse(ok);
            check_val("ma_wait", ok, 1);
            check_val("ma_value", adc_data_o, 10);
            check_val("ma_period", cyc - t_prev, 8);
            t_prev = cyc;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
